sram_1p_rr_ctrl: RTL and testbench

- Two-requester round-robin controller for the single-port 8192x32 SRAM macro (MEN/WEN/REN/ADDR/DIN/DLY/DOUT interface).
- Arbitrates one access per clock and registers all macro inputs.
- Returns read data to the issuing port with fixed latency.
- Optionally zero-fills the whole array after reset before granting any requester.

---
 rtl/sram_1p_rr_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_1p_rr_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1p_rr_ctrl.sv
// Two-requester round-robin front end for a single-port SRAM macro: one access per
// clock, registered macro inputs, fixed 2-cycle read return, optional zero-fill.
module sram_1p_rr_ctrl #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              P0_REQ,
    output logic              P0_GNT,
    input  logic              P0_WE,
    input  logic [ADDR_W-1:0] P0_ADDR,
    input  logic [DATA_W-1:0] P0_WDATA,
    output logic              P0_RVALID,
    output logic [DATA_W-1:0] P0_RDATA,
    input  logic              P1_REQ,
    output logic              P1_GNT,
    input  logic              P1_WE,
    input  logic [ADDR_W-1:0] P1_ADDR,
    input  logic [DATA_W-1:0] P1_WDATA,
    output logic              P1_RVALID,
    output logic [DATA_W-1:0] P1_RDATA,
    output logic              M_MEN,
    output logic              M_WEN,
    output logic              M_REN,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_DIN,
    output logic              M_DLY,
    input  logic [DATA_W-1:0] M_DOUT,
    output logic              INIT_DONE
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

    state_t            state_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic              rr_q;
    tag_t              tag_q [2];
    logic              m_men_q, m_wen_q, m_ren_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_din_q;
    logic              p0_rvalid_q, p1_rvalid_q;
    logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

    logic              xfer;
    logic              xfer_we;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_wdata;

    // Handshake: Px_REQ is valid, Px_GNT is ready; a transfer happens at a posedge
    // where both are high. GNT depends only on REQ and registered state.
    always_comb begin
        P0_GNT = 1'b0;
        P1_GNT = 1'b0;
        if (state_q == ST_RUN) begin
            if (P0_REQ && (!P1_REQ || !rr_q)) begin
                P0_GNT = 1'b1;
            end else if (P1_REQ) begin
                P1_GNT = 1'b1;
            end
        end
    end

    assign xfer       = P0_GNT | P1_GNT;
    assign xfer_we    = P0_GNT ? P0_WE    : P1_WE;
    assign xfer_addr  = P0_GNT ? P0_ADDR  : P1_ADDR;
    assign xfer_wdata = P0_GNT ? P0_WDATA : P1_WDATA;
    assign cnt_d      = cnt_q + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= INIT_EN ? ST_INIT : ST_RUN;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            tag_q[0]    <= '0;
            tag_q[1]    <= '0;
            m_men_q     <= 1'b0;
            m_wen_q     <= 1'b0;
            m_ren_q     <= 1'b0;
            m_addr_q    <= '0;
            m_din_q     <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            // Read tag rides along with the access; stage 1 lines up with macro DOUT.
            tag_q[0]    <= '{valid: xfer & ~xfer_we, port: P1_GNT};
            tag_q[1]    <= tag_q[0];
            p0_rvalid_q <= tag_q[1].valid & ~tag_q[1].port;
            p1_rvalid_q <= tag_q[1].valid &  tag_q[1].port;
            if (tag_q[1].valid && !tag_q[1].port) p0_rdata_q <= M_DOUT;
            if (tag_q[1].valid &&  tag_q[1].port) p1_rdata_q <= M_DOUT;

            case (state_q)
                ST_INIT: begin
                    m_men_q  <= 1'b1;
                    m_wen_q  <= 1'b1;
                    m_ren_q  <= 1'b0;
                    m_addr_q <= cnt_q[ADDR_W-1:0];
                    m_din_q  <= '0;
                    cnt_q    <= cnt_d;
                    if (cnt_d[ADDR_W]) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    m_men_q <= xfer;
                    m_wen_q <= xfer & xfer_we;
                    m_ren_q <= xfer & ~xfer_we;
                    if (xfer) begin
                        m_addr_q <= xfer_addr;
                        if (xfer_we) m_din_q <= xfer_wdata;
                        rr_q <= P0_GNT;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // INIT_DONE doubles as the FSM state probe.
    assign INIT_DONE = (state_q == ST_RUN);
    assign M_MEN     = m_men_q;
    assign M_WEN     = m_wen_q;
    assign M_REN     = m_ren_q;
    assign M_ADDR    = m_addr_q;
    assign M_DIN     = m_din_q;
    assign M_DLY     = 1'b1;
    assign P0_RVALID = p0_rvalid_q;
    assign P1_RVALID = p1_rvalid_q;
    assign P0_RDATA  = p0_rdata_q;
    assign P1_RDATA  = p1_rdata_q;

endmodule

// File: tb/tb_sram_1p_rr_ctrl.sv
// Bench for sram_1p_rr_ctrl: a 16-word zero-filling instance under random traffic
// against a transaction-level model, plus a full-size instance without zero-fill.
module tb_sram_1p_rr_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_tot = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A: ADDR_W=4, INIT_EN=1 ----------------
  logic        a_p0_req = 1'b0, a_p0_we = 1'b0, a_p1_req = 1'b0, a_p1_we = 1'b0;
  logic [3:0]  a_p0_addr = '0, a_p1_addr = '0;
  logic [31:0] a_p0_wdata = '0, a_p1_wdata = '0;
  logic        a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid;
  logic [31:0] a_p0_rdata, a_p1_rdata;
  logic        a_m_men, a_m_wen, a_m_ren, a_m_dly, a_init_done;
  logic [3:0]  a_m_addr;
  logic [31:0] a_m_din;
  logic [31:0] a_m_dout = '0;

  sram_1p_rr_ctrl #(.ADDR_W(4), .DATA_W(32), .INIT_EN(1'b1)) dut_a (
    .CLK(clk), .RST(rst),
    .P0_REQ(a_p0_req), .P0_GNT(a_p0_gnt), .P0_WE(a_p0_we), .P0_ADDR(a_p0_addr),
    .P0_WDATA(a_p0_wdata), .P0_RVALID(a_p0_rvalid), .P0_RDATA(a_p0_rdata),
    .P1_REQ(a_p1_req), .P1_GNT(a_p1_gnt), .P1_WE(a_p1_we), .P1_ADDR(a_p1_addr),
    .P1_WDATA(a_p1_wdata), .P1_RVALID(a_p1_rvalid), .P1_RDATA(a_p1_rdata),
    .M_MEN(a_m_men), .M_WEN(a_m_wen), .M_REN(a_m_ren), .M_ADDR(a_m_addr),
    .M_DIN(a_m_din), .M_DLY(a_m_dly), .M_DOUT(a_m_dout), .INIT_DONE(a_init_done)
  );

  // Macro stand-in for A, seeded with garbage so the zero-fill is visible.
  logic [31:0] mem_a [16];
  logic        mem_a_seeded = 1'b0;
  always @(posedge clk) begin
    if (!mem_a_seeded) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= $urandom;
      mem_a_seeded <= 1'b1;
    end else if (a_m_men) begin
      if (a_m_wen) mem_a[a_m_addr] <= a_m_din;
      if (a_m_ren) a_m_dout <= mem_a[a_m_addr];
    end
  end

  // ---------------- instance B: ADDR_W=13, INIT_EN=0 ----------------
  logic        b_p0_req = 1'b0, b_p0_we = 1'b0, b_p1_req = 1'b0, b_p1_we = 1'b0;
  logic [12:0] b_p0_addr = '0, b_p1_addr = '0;
  logic [31:0] b_p0_wdata = '0, b_p1_wdata = '0;
  logic        b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid;
  logic [31:0] b_p0_rdata, b_p1_rdata;
  logic        b_m_men, b_m_wen, b_m_ren, b_m_dly, b_init_done;
  logic [12:0] b_m_addr;
  logic [31:0] b_m_din;
  logic [31:0] b_m_dout = '0;

  sram_1p_rr_ctrl #(.ADDR_W(13), .DATA_W(32), .INIT_EN(1'b0)) dut_b (
    .CLK(clk), .RST(rst),
    .P0_REQ(b_p0_req), .P0_GNT(b_p0_gnt), .P0_WE(b_p0_we), .P0_ADDR(b_p0_addr),
    .P0_WDATA(b_p0_wdata), .P0_RVALID(b_p0_rvalid), .P0_RDATA(b_p0_rdata),
    .P1_REQ(b_p1_req), .P1_GNT(b_p1_gnt), .P1_WE(b_p1_we), .P1_ADDR(b_p1_addr),
    .P1_WDATA(b_p1_wdata), .P1_RVALID(b_p1_rvalid), .P1_RDATA(b_p1_rdata),
    .M_MEN(b_m_men), .M_WEN(b_m_wen), .M_REN(b_m_ren), .M_ADDR(b_m_addr),
    .M_DIN(b_m_din), .M_DLY(b_m_dly), .M_DOUT(b_m_dout), .INIT_DONE(b_init_done)
  );

  logic [31:0] mem_b [8192];
  always @(posedge clk) begin
    if (b_m_men) begin
      if (b_m_wen) mem_b[b_m_addr] <= b_m_din;
      if (b_m_ren) b_m_dout <= mem_b[b_m_addr];
    end
  end

  // ---------------- scoreboard ----------------
  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
  endfunction

  // Transaction-level model of A: memory contents, per-port expected responses
  // with the cycle they are due, and what the macro pins must show next cycle.
  logic [31:0] ref_mem [16];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          due_q0 [$];
  int          due_q1 [$];
  logic [31:0] last0, last1;
  logic        favour_p1;
  bit          rel_valid = 1'b0;
  int          rel_base = 0;
  logic        w_men, w_wen, w_ren;
  logic [3:0]  w_addr;
  logic [31:0] w_din;

  task automatic compare_loop();
    int          j;
    logic        run, g0, g1, v0, v1, we;
    logic [3:0]  ad;
    logic [31:0] wd;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_p0_gnt", a_p0_gnt, 0);
        chk("rst_p1_gnt", a_p1_gnt, 0);
        chk("rst_p0_rvalid", a_p0_rvalid, 0);
        chk("rst_p1_rvalid", a_p1_rvalid, 0);
        chk("rst_p0_rdata", a_p0_rdata, 0);
        chk("rst_p1_rdata", a_p1_rdata, 0);
        chk("rst_m_men", a_m_men, 0);
        chk("rst_m_wen", a_m_wen, 0);
        chk("rst_m_ren", a_m_ren, 0);
        chk("rst_m_addr", a_m_addr, 0);
        chk("rst_m_din", a_m_din, 0);
        chk("rst_init_done", a_init_done, 0);
        chk("rst_b_init_done", b_init_done, 1);
        exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        last0 = '0; last1 = '0; favour_p1 = 1'b0; rel_valid = 1'b0;
        w_men = 1'b0; w_wen = 1'b0; w_ren = 1'b0; w_addr = '0; w_din = '0;
      end else begin
        if (!rel_valid) begin
          rel_valid = 1'b1;
          rel_base  = cyc;
        end
        j   = cyc - rel_base;
        run = (j >= 16);
        chk("init_done", a_init_done, run);
        chk("m_men", a_m_men, w_men);
        chk("m_wen", a_m_wen, w_wen);
        chk("m_ren", a_m_ren, w_ren);
        chk("m_addr", a_m_addr, w_addr);
        chk("m_din", a_m_din, w_din);
        v0 = (due_q0.size() > 0) && (due_q0[0] == cyc);
        v1 = (due_q1.size() > 0) && (due_q1[0] == cyc);
        if (v0) begin last0 = exp_q0.pop_front(); void'(due_q0.pop_front()); end
        if (v1) begin last1 = exp_q1.pop_front(); void'(due_q1.pop_front()); end
        chk("p0_rvalid", a_p0_rvalid, v0);
        chk("p1_rvalid", a_p1_rvalid, v1);
        chk("p0_rdata", a_p0_rdata, last0);
        chk("p1_rdata", a_p1_rdata, last1);
        g0 = run && a_p0_req && (!a_p1_req || !favour_p1);
        g1 = run && a_p1_req && !g0;
        chk("p0_gnt", a_p0_gnt, g0);
        chk("p1_gnt", a_p1_gnt, g1);
        if (!run) begin
          w_men = 1'b1; w_wen = 1'b1; w_ren = 1'b0; w_addr = 4'(j); w_din = '0;
        end else if (g0 || g1) begin
          we = g0 ? a_p0_we    : a_p1_we;
          ad = g0 ? a_p0_addr  : a_p1_addr;
          wd = g0 ? a_p0_wdata : a_p1_wdata;
          if (we) begin
            ref_mem[ad] = wd;
            w_din = wd;
          end else if (g0) begin
            exp_q0.push_back(ref_mem[ad]); due_q0.push_back(cyc + 3);
          end else begin
            exp_q1.push_back(ref_mem[ad]); due_q1.push_back(cyc + 3);
          end
          w_men = 1'b1; w_wen = we; w_ren = !we; w_addr = ad;
          favour_p1 = g0;
        end else begin
          w_men = 1'b0; w_wen = 1'b0; w_ren = 1'b0;
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic a_drive(input logic r0, input logic w0, input logic [3:0] ad0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [3:0] ad1, input logic [31:0] d1);
    a_p0_req = r0; a_p0_we = w0; a_p0_addr = ad0; a_p0_wdata = d0;
    a_p1_req = r1; a_p1_we = w1; a_p1_addr = ad1; a_p1_wdata = d1;
  endtask

  task automatic a_random();
    a_drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic a_wait_init(input string name);
    int n_done = 0;
    int stray = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (a_p0_rvalid || a_p1_rvalid) stray++;
      if (a_init_done) begin
        n_done = n;
        break;
      end
      a_random();
    end
    chk(name, n_done, 16);
    chk({name, "_no_rvalid"}, stray, 0);
  endtask

  task automatic a_branch();
    a_wait_init("init_cycles");
    for (int i = 0; i < 16; i++) begin
      tick();
      a_drive(1'b1, 1'b0, 4'(i), '0, 1'b0, 1'b0, '0, '0);
      #1 chk("sweep_gnt", a_p0_gnt, 1);
    end
    tick();
    a_drive(1'b1, 1'b1, 4'h1, 32'hAAAA_0001, 1'b0, 1'b0, '0, '0);
    #1 chk("wr1_gnt", a_p0_gnt, 1);
    tick();
    a_drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 4'h2, 32'hBBBB_0002);
    #1 chk("wr2_gnt", a_p1_gnt, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      a_drive(1'b1, 1'b0, 4'h1, '0, 1'b1, 1'b0, 4'h2, '0);
      #1;
      chk("alt_p0_gnt", a_p0_gnt, (i % 2) == 0);
      chk("alt_p1_gnt", a_p1_gnt, (i % 2) == 1);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      a_drive(1'b0, 1'b0, '0, '0, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      #1 chk("p1_alone_gnt", a_p1_gnt, 1);
    end
    repeat (400) begin
      tick();
      a_random();
    end
    tick();
    a_drive(1'b1, 1'b1, 4'h3, 32'h1234_5678, 1'b0, 1'b0, '0, '0);
    tick();
    a_drive(1'b1, 1'b0, 4'h3, '0, 1'b0, 1'b0, '0, '0);
    tick();
    a_drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (3) tick();
    chk("pre_rst_rdata", a_p0_rdata, 32'h1234_5678);
    a_drive(1'b1, 1'b0, 4'h3, '0, 1'b0, 1'b0, '0, '0);
    #1 chk("pre_rst_gnt", a_p0_gnt, 1);
    tick();
    a_drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_rdata", a_p0_rdata, 0);
    chk("async_rst_maddr", a_m_addr, 0);
    chk("async_rst_done", a_init_done, 0);
    repeat (2) tick();
    rst = 1'b0;
    a_wait_init("reinit_cycles");
    repeat (40) begin
      tick();
      a_random();
    end
    tick();
    a_drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (4) tick();
  endtask

  task automatic b_branch();
    int          gcyc, at, nseen;
    logic        seen1;
    logic [31:0] data;
    b_p0_req = 1'b1; b_p0_we = 1'b1; b_p0_addr = 13'h1ABC; b_p0_wdata = 32'hDEAD_BEEF;
    #1 chk("b_first_gnt", b_p0_gnt, 1);
    tick();
    b_p0_we = 1'b0;
    #1 chk("b_rd_gnt", b_p0_gnt, 1);
    gcyc = cyc;
    tick();
    b_p0_req = 1'b0;
    nseen = 0; at = 0; seen1 = 1'b0; data = '0;
    repeat (6) begin
      @(negedge clk);
      if (b_p1_rvalid) seen1 = 1'b1;
      if (b_p0_rvalid) begin
        nseen++;
        at = cyc;
        data = b_p0_rdata;
      end
    end
    chk("b_rvalid_count", nseen, 1);
    chk("b_rvalid_latency", at - (gcyc + 1), 2);
    chk("b_rdata", data, 32'hDEAD_BEEF);
    chk("b_p1_rvalid", seen1, 0);
  endtask

  task automatic run_all();
    repeat (3) tick();
    chk("b_init_done_in_rst", b_init_done, 1);
    chk("a_init_done_in_rst", a_init_done, 0);
    chk("a_m_dly", a_m_dly, 1);
    chk("b_m_dly", b_m_dly, 1);
    rst = 1'b0;
    fork
      a_branch();
      b_branch();
    join
  endtask

  initial begin
    #1 rst = 1'b1;
    fork
      compare_loop();
      run_all();
    join_any
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
